// File: rtl/wave_display_pkg.sv
// Shared definitions for the waveform display path: FSM encoding, window
// geometry and the sample-to-screen-row mapping.
package wave_display_pkg;

    localparam int WIN_W           = 512;
    localparam int WIN_H           = 256;
    localparam int SAMPLES_PER_BUF = 256;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_SCAN = 1'b1;

    typedef struct packed {
        logic [7:0] row;
        logic [8:0] col;
        logic       in_win;
    } stage1_t;

    // Offset-binary sample to screen row; larger samples sit higher on screen.
    function automatic logic [7:0] plot_row(input logic [7:0] sample);
        return 8'd255 - sample;
    endfunction

endpackage

// File: rtl/wave_display_if.sv
// Read-side bus between the display and the capture stage's sample RAM.
interface wave_display_if;
    logic [8:0] read_address;
    logic [7:0] read_value;
    logic       read_index;
    logic       wave_display_idle;

    modport master (
        output read_address,
        output wave_display_idle,
        input  read_value,
        input  read_index
    );

    modport slave (
        input  read_address,
        input  wave_display_idle,
        output read_value,
        output read_index
    );
endinterface

// File: rtl/wave_display_dff.sv
// Plain flop primitives with synchronous active-high reset to zero, with and
// without a load enable.
module dffr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end
endmodule

module dffre #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/wave_display_pixel_compare.sv
// Decides whether a window row lies on the vertical segment joining the
// previous and current samples (inclusive at both ends).
module wave_pixel_compare
    import wave_display_pkg::*;
(
    input  logic [7:0] prev,
    input  logic [7:0] cur,
    input  logic [7:0] row,
    output logic       lit
);
    logic [7:0] pr;
    logic [7:0] cr;
    logic [7:0] lo;
    logic [7:0] hi;

    always_comb begin
        pr  = plot_row(prev);
        cr  = plot_row(cur);
        lo  = (pr < cr) ? pr : cr;
        hi  = (pr < cr) ? cr : pr;
        lit = (row >= lo) && (row <= hi);
    end
endmodule

// File: rtl/wave_display.sv
// Rasterises the idle half of the capture RAM as a line trace inside a
// 512x256 window of the VGA stream; two cycles from x/y to r/g/b.
module wave_display
    import wave_display_pkg::*;
#(
    parameter int          X_START   = 256,
    parameter int          Y_START   = 0,
    parameter logic [23:0] TRACE_RGB = 24'hFFFFFF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [10:0]    x,
    input  logic [9:0]     y,
    input  logic           valid,
    wave_display_if.master ram,
    output logic           valid_pixel,
    output logic [7:0]     r,
    output logic [7:0]     g,
    output logic [7:0]     b
);
    localparam logic [11:0] X_LO  = 12'(X_START);
    localparam logic [11:0] X_HI  = 12'(X_START + WIN_W);
    localparam logic [10:0] Y_LO  = 11'(Y_START);
    localparam logic [10:0] Y_HI  = 11'(Y_START + WIN_H);
    localparam logic [8:0]  X_OFF = 9'(X_START);
    localparam logic [7:0]  Y_OFF = 8'(Y_START);

    logic       in_win;
    logic       scan_done;
    logic [8:0] col;
    logic [7:0] row;

    always_comb begin
        in_win    = valid
                  && ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI)
                  && ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
        scan_done = valid && ({1'b0, y} >= Y_HI);
        col       = x[8:0] - X_OFF;
        row       = y[7:0] - Y_OFF;
    end

    // Frame FSM
    logic [0:0] state_reg;
    logic [0:0] state_next;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STATE_IDLE: if (in_win)    state_next = STATE_SCAN;
            STATE_SCAN: if (scan_done) state_next = STATE_IDLE;
            default:                   state_next = STATE_IDLE;
        endcase
    end

    dffr #(.WIDTH(1)) u_state (
        .clk   (clk),
        .reset (reset),
        .d     (state_next),
        .q     (state_reg)
    );

    // Buffer half is frozen for the whole frame so a swap cannot tear the trace.
    logic buf_sel_reg;

    dffre #(.WIDTH(1)) u_buf_sel (
        .clk   (clk),
        .reset (reset),
        .en    (state_reg == STATE_IDLE),
        .d     (~ram.read_index),
        .q     (buf_sel_reg)
    );

    assign ram.read_address      = {buf_sel_reg, col[8:1]};
    assign ram.wave_display_idle = (state_reg == STATE_IDLE) && !in_win;

    // Stage 1: coordinates line up with the RAM data returned this cycle.
    stage1_t s1_next;
    stage1_t s1_reg;

    always_comb begin
        s1_next.row    = row;
        s1_next.col    = col;
        s1_next.in_win = in_win;
    end

    dffr #(.WIDTH($bits(stage1_t))) u_stage1 (
        .clk   (clk),
        .reset (reset),
        .d     (s1_next),
        .q     (s1_reg)
    );

    logic [7:0] cur;
    logic [7:0] idx_d1;
    logic [7:0] cur_last_reg;
    logic [7:0] idx_last_reg;
    logic [7:0] prev_reg;
    logic [7:0] prev_next;

    assign cur    = ram.read_value;
    assign idx_d1 = s1_reg.col[8:1];

    // On entering a new sample the last one seen becomes prev; at column 0
    // prev collapses onto cur so no segment joins the end of the previous row.
    always_comb begin
        prev_next = prev_reg;
        if (s1_reg.col == 9'd0)
            prev_next = cur;
        else if (idx_d1 != idx_last_reg)
            prev_next = cur_last_reg;
    end

    dffre #(.WIDTH(24)) u_prev (
        .clk   (clk),
        .reset (reset),
        .en    (s1_reg.in_win),
        .d     ({prev_next, cur, idx_d1}),
        .q     ({prev_reg, cur_last_reg, idx_last_reg})
    );

    logic cmp_lit;
    logic lit;

    wave_pixel_compare u_compare (
        .prev (prev_next),
        .cur  (cur),
        .row  (s1_reg.row),
        .lit  (cmp_lit)
    );

    assign lit = s1_reg.in_win && cmp_lit;

    // Stage 2: output registers, channel order {r, g, b}.
    logic [7:0] chan_reg [3];

    dffr #(.WIDTH(1)) u_valid_pixel (
        .clk   (clk),
        .reset (reset),
        .d     (s1_reg.in_win),
        .q     (valid_pixel)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            dffr #(.WIDTH(8)) u_chan (
                .clk   (clk),
                .reset (reset),
                .d     (lit ? TRACE_RGB[23 - 8*gi -: 8] : 8'h00),
                .q     (chan_reg[gi])
            );
        end
    endgenerate

    assign r = chan_reg[0];
    assign g = chan_reg[1];
    assign b = chan_reg[2];

endmodule

// File: tb/tb_wave_display.sv
// Directed bench for wave_display: stimulus pushes expected pixels into a
// queue, a negedge monitor pops and compares whenever valid_pixel is high.
module tb_wave_display;
    localparam int X_START = 256;
    localparam int Y_START = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        valid_pixel;
    logic [7:0]  r, g, b;

    wave_display_if ram_if ();

    wave_display #(
        .X_START   (X_START),
        .Y_START   (Y_START),
        .TRACE_RGB (24'hFFFFFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .valid       (valid),
        .ram         (ram_if.master),
        .valid_pixel (valid_pixel),
        .r           (r),
        .g           (g),
        .b           (b)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [512];
    always @(posedge clk) ram_if.read_value <= mem[ram_if.read_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          px;
        int          py;
        logic [23:0] rgb;
    } exp_t;

    exp_t q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   probe_cyc = -100;
    bit   probe_en  = 1'b0;
    bit   exp_buf   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Line-trace reference: segment between sample idx-1 and idx, sample 0 flat.
    function automatic logic [23:0] model_rgb(input int col, input int row, input bit bsel);
        int idx, s, p, pr, cr, lo, hi;
        idx = col / 2;
        s   = int'(mem[bsel*256 + idx]);
        p   = (idx == 0) ? s : int'(mem[bsel*256 + idx - 1]);
        pr  = 255 - p;
        cr  = 255 - s;
        lo  = (pr < cr) ? pr : cr;
        hi  = (pr < cr) ? cr : pr;
        return (row >= lo && row <= hi) ? 24'hFFFFFF : 24'h000000;
    endfunction

    task automatic drive(input int xx, input int yy, input bit vv);
        @(posedge clk);
        #1;
        x     = 11'(xx);
        y     = 10'(yy);
        valid = vv;
        if (vv && xx >= X_START && xx < X_START + 512 && yy >= Y_START && yy < Y_START + 256)
            q.push_back('{xx, yy, model_rgb(xx - X_START, yy - Y_START, exp_buf)});
    endtask

    task automatic drive_row(input int yy);
        for (int xx = X_START - 2; xx < X_START + 514; xx++) begin
            drive(xx, yy, 1'b1);
            if (probe_en && xx == X_START + 22) begin
                probe_cyc = cyc;
                probe_en  = 1'b0;
            end
        end
    endtask

    // Monitor: compare every presented pixel, plus the exact-latency probe.
    always @(negedge clk) begin
        if (valid_pixel) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got rgb=%0h, expected no pixel", {r, g, b});
            end else begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if ({r, g, b} !== e.rgb || ^{r, g, b} === 1'bx) begin
                    errors++;
                    $display("FAIL pixel(%0d,%0d): got %0h expected %0h", e.px, e.py, {r, g, b}, e.rgb);
                end
            end
        end
        if (cyc == probe_cyc + 1) check("latency_pixel_21_black", {8'h0, r, g, b}, 32'h0);
        if (cyc == probe_cyc + 2) check("latency_pixel_22_white", {8'h0, r, g, b}, 32'hFFFFFF);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 8'd0;
            mem[256 + i] = 8'd128;
        end
        reset = 1'b1;
        x = '0; y = '0; valid = 1'b0;
        ram_if.read_index = 1'b0;

        // Reset state and an out-of-window position
        repeat (2) @(posedge clk);
        #1; x = 11'd100; y = 10'd50; valid = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("reset_valid_pixel", {31'h0, valid_pixel}, 32'h0);
        check("reset_rgb", {8'h0, r, g, b}, 32'h0);
        check("reset_idle", {31'h0, ram_if.wave_display_idle}, 32'h1);

        for (int i = 0; i < 4; i++) begin
            drive(100, 50, 1'b1);
            ram_if.read_index = i[0];
            drive(100, 50, 1'b1);
            #1;
            check("idle_addr_msb_follows", {31'h0, ram_if.read_address[8]}, {31'h0, ~i[0]});
            check("idle_outside_window", {31'h0, ram_if.wave_display_idle}, 32'h1);
        end
        @(negedge clk);
        check("outside_valid_pixel", {31'h0, valid_pixel}, 32'h0);
        ram_if.read_index = 1'b0;
        drive(100, 50, 1'b1);
        drive(100, 50, 1'b1);

        // Address generation at the left edge of the window
        drive(256, 0, 1'b1);
        #1;
        check("addr_x256", {23'h0, ram_if.read_address}, 32'h100);
        check("idle_in_window", {31'h0, ram_if.wave_display_idle}, 32'h0);
        drive(259, 0, 1'b1);
        #1;
        check("addr_x259", {23'h0, ram_if.read_address}, 32'h101);

        // Flat 128: only row 127 lit
        drive_row(126);
        drive_row(127);
        drive_row(128);

        // Full-height segment between samples 10 (0) and 11 (255)
        mem[256 + 10] = 8'd0;
        mem[256 + 11] = 8'd255;
        probe_en = 1'b1;
        drive_row(0);
        drive_row(128);
        drive_row(255);

        // Buffer swap request mid-frame must not move the read half
        for (int xx = X_START - 2; xx < X_START + 10; xx++) drive(xx, 10, 1'b1);
        ram_if.read_index = 1'b1;
        drive(X_START + 10, 10, 1'b1);
        #1;
        check("midframe_addr_msb_held", {31'h0, ram_if.read_address[8]}, 32'h1);
        for (int xx = X_START + 11; xx < X_START + 514; xx++) drive(xx, 10, 1'b1);
        #1;
        check("row_end_addr_msb_held", {31'h0, ram_if.read_address[8]}, 32'h1);
        drive(100, 256, 1'b1);
        drive(100, 256, 1'b1);
        #1;
        check("idle_after_window", {31'h0, ram_if.wave_display_idle}, 32'h1);
        drive(100, 256, 1'b1);
        #1;
        check("addr_msb_after_exit", {31'h0, ram_if.read_address[8]}, 32'h0);
        ram_if.read_index = 1'b0;
        repeat (3) drive(100, 256, 1'b1);

        // Reset in the middle of row 100 with lit pixels in flight
        for (int k = 0; k <= 40; k++) mem[256 + k] = 8'd155;
        for (int xx = X_START - 2; xx < X_START + 50; xx++) drive(xx, 100, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        x = 11'(X_START + 50);
        @(posedge clk); #1;
        q.delete();
        reset = 1'b0;
        x = 11'd100; y = 10'd100; valid = 1'b1;
        @(negedge clk);
        check("post_reset_valid_pixel", {31'h0, valid_pixel}, 32'h0);
        check("post_reset_rgb", {8'h0, r, g, b}, 32'h0);
        check("post_reset_idle", {31'h0, ram_if.wave_display_idle}, 32'h1);
        drive_row(100);
        drive(100, 256, 1'b1);
        repeat (4) drive(100, 256, 1'b0);
        @(negedge clk);
        check("queue_drained", q.size(), 32'h0);
        check("probe_fired", {31'h0, probe_cyc >= 0}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
